// File: rtl/iob_cache_be_arb_pkg.sv
// Shared definitions for the cache back-end arbiter: FSM state encodings,
// default widths and a beat-counter width helper.
package iob_cache_be_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BEAT  = 2'd2
   } arb_state_t;

   localparam int DEF_BE_ADDR_W = 24;
   localparam int DEF_BE_DATA_W = 32;
   localparam int DEF_LINE2BE_W = 2;
   localparam int DEF_CNT_W     = 32;

   // A single-beat refill still needs a 1-bit register to stay legal.
   function automatic int beat_cnt_w(input int line2be_w);
      return (line2be_w > 0) ? line2be_w : 1;
   endfunction

endpackage

// File: rtl/iob_cache_be_arb_cnt.sv
// Saturating event counter with synchronous clear, used for the optional
// arbiter performance counters.
module iob_cache_be_arb_cnt #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         reset_n_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cnt_reg <= '0;
      end else if (clr_i) begin
         cnt_reg <= '0;
      end else if (inc_i && !(&cnt_reg)) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign cnt_o = cnt_reg;

endmodule

// File: rtl/iob_cache_be_arbiter_iob.sv
// Shares the cache back-end port between line refills and write-through,
// write first. IOB_CACHE_BE_ARB_CNT_EN adds grant/stall counters.
module iob_cache_be_arbiter_iob
   import iob_cache_be_arb_pkg::*;
#(
   parameter int BE_ADDR_W = DEF_BE_ADDR_W,
   parameter int BE_DATA_W = DEF_BE_DATA_W,
   parameter int LINE2BE_W = DEF_LINE2BE_W,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   rd_valid_i,
   input  logic [BE_ADDR_W-1:0]   rd_addr_i,
   output logic                   rd_ack_o,
   output logic [BE_DATA_W-1:0]   rd_rdata_o,
   input  logic                   wr_valid_i,
   input  logic [BE_ADDR_W-1:0]   wr_addr_i,
   input  logic [BE_DATA_W-1:0]   wr_wdata_i,
   input  logic [BE_DATA_W/8-1:0] wr_wstrb_i,
   output logic                   wr_ack_o,
   output logic                   be_valid_o,
   output logic [BE_ADDR_W-1:0]   be_addr_o,
   output logic [BE_DATA_W-1:0]   be_wdata_o,
   output logic [BE_DATA_W/8-1:0] be_wstrb_o,
   input  logic                   be_ack_i,
   input  logic [BE_DATA_W-1:0]   be_rdata_i,
   output logic                   busy_o
`ifdef IOB_CACHE_BE_ARB_CNT_EN
   ,
   input  logic                   cnt_clr_i,
   output logic [CNT_W-1:0]       rd_grants_o,
   output logic [CNT_W-1:0]       wr_grants_o,
   output logic [CNT_W-1:0]       rd_stall_o
`endif
);

   localparam int BCNT_W = beat_cnt_w(LINE2BE_W);
   localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'((1 << LINE2BE_W) - 1);

   arb_state_t        state_reg;
   logic [BCNT_W-1:0] beat_cnt_reg;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_reg    <= IDLE;
         beat_cnt_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (wr_valid_i)      state_reg <= WR_BEAT;
               else if (rd_valid_i) state_reg <= RD_BURST;
            end
            WR_BEAT: begin
               if (be_ack_i) state_reg <= IDLE;
            end
            RD_BURST: begin
               if (be_ack_i) begin
                  if (beat_cnt_reg == BEAT_LAST) begin
                     state_reg    <= IDLE;
                     beat_cnt_reg <= '0;
                  end else begin
                     beat_cnt_reg <= beat_cnt_reg + 1'b1;
                  end
               end
            end
            default: begin
               state_reg    <= IDLE;
               beat_cnt_reg <= '0;
            end
         endcase
      end
   end

   // be_valid_o depends only on the state and the granted requester's valid.
   always_comb begin
      be_valid_o = 1'b0;
      be_addr_o  = '0;
      be_wdata_o = '0;
      be_wstrb_o = '0;
      rd_ack_o   = 1'b0;
      wr_ack_o   = 1'b0;
      case (state_reg)
         WR_BEAT: begin
            be_valid_o = wr_valid_i;
            be_addr_o  = wr_addr_i;
            be_wdata_o = wr_wdata_i;
            be_wstrb_o = wr_wstrb_i;
            wr_ack_o   = be_ack_i;
         end
         RD_BURST: begin
            be_valid_o = rd_valid_i;
            be_addr_o  = rd_addr_i;
            rd_ack_o   = be_ack_i;
         end
         default: ;
      endcase
   end

   assign rd_rdata_o = be_rdata_i;
   assign busy_o     = (state_reg != IDLE);

`ifdef IOB_CACHE_BE_ARB_CNT_EN
   logic rd_grant, wr_grant, rd_stall;

   assign wr_grant = (state_reg == IDLE) && wr_valid_i;
   assign rd_grant = (state_reg == IDLE) && !wr_valid_i && rd_valid_i;
   assign rd_stall = rd_valid_i && (state_reg != RD_BURST);

   iob_cache_be_arb_cnt #(.W(CNT_W)) u_rd_grants (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .clr_i(cnt_clr_i),
      .inc_i(rd_grant), .cnt_o(rd_grants_o)
   );
   iob_cache_be_arb_cnt #(.W(CNT_W)) u_wr_grants (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .clr_i(cnt_clr_i),
      .inc_i(wr_grant), .cnt_o(wr_grants_o)
   );
   iob_cache_be_arb_cnt #(.W(CNT_W)) u_rd_stall (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .clr_i(cnt_clr_i),
      .inc_i(rd_stall), .cnt_o(rd_stall_o)
   );
`endif

endmodule
